// File: rtl/lsu_mem_stage_if.sv
// Data-cache port of the LSU memory stage: req/gnt request channel plus rvalid response.
// The stage is the master; the cache (or a bench model) is the slave.
interface lsu_mem_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32/RV64 memory stage: one load/store in flight, byte-lane alignment, load extension, faults.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts a cache access after TIMEOUT_CYCLES.
module lsu_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic                  ex_load_i,
  input  logic                  ex_store_i,
  input  logic [1:0]            ex_size_i,
  input  logic                  ex_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic [4:0]            ex_rd_i,
  lsu_mem_stage_if.master       dc,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [4:0]            wb_rd_o,
  output logic                  mem_stall_o,
  output logic                  mem_exception_o,
  output logic [1:0]            mem_exc_code_o,
  output logic [ADDR_WIDTH-1:0] mem_exc_addr_o
);
  localparam int NB   = DATA_WIDTH/8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef struct packed {
    logic                  load;
    logic                  store;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [4:0]            rd;
  } mem_req_t;

  state_e                state_q, state_d;
  mem_req_t              req_q;
  logic                  kill_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic                  exc_q;
  logic [1:0]            exc_code_q;
  logic                  tmo;

  logic                  accept, passthru, misal, killed, sign_bit;
  logic [OFFW-1:0]       off;
  logic [7:0]            be_base;
  logic [DATA_WIDTH-1:0] rd_shift, ext_mask, load_data;

  assign accept   = (state_q == IDLE) && ex_valid_i && !flush_i;
  assign passthru = !ex_load_i && !ex_store_i;
  assign killed   = kill_q || flush_i;
  assign off      = req_q.addr[OFFW-1:0];

  always_comb begin
    misal = 1'b0;
    case (ex_size_i)
      2'b01:   misal = ex_addr_i[0];
      2'b10:   misal = |ex_addr_i[1:0];
      2'b11:   misal = (DATA_WIDTH == 32) || (|ex_addr_i[2:0]);
      default: misal = 1'b0;
    endcase
  end

  // Extension by mask: bits above the access size are replaced by the sign when signed.
  always_comb begin
    be_base  = 8'hFF;
    ext_mask = '1;
    sign_bit = 1'b0;
    rd_shift = dc.rdata >> {off, 3'b000};
    case (req_q.size)
      2'b00:   begin be_base = 8'h01; ext_mask = DATA_WIDTH'(64'hFF);        sign_bit = rd_shift[7];  end
      2'b01:   begin be_base = 8'h03; ext_mask = DATA_WIDTH'(64'hFFFF);      sign_bit = rd_shift[15]; end
      2'b10:   begin be_base = 8'h0F; ext_mask = DATA_WIDTH'(64'hFFFF_FFFF); sign_bit = rd_shift[31]; end
      default: ;
    endcase
    load_data = (rd_shift & ext_mask) | ((sign_bit && !req_q.uns) ? ~ext_mask : '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (passthru || misal) ? DONE : REQ;
      REQ:  if (tmo) state_d = killed ? IDLE : DONE;
            else if (dc.gnt) state_d = WAIT;
      WAIT: if (tmo || dc.rvalid) state_d = killed ? IDLE : DONE;
      DONE: if (flush_i || wb_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_q      <= '0;
      kill_q     <= 1'b0;
      wb_data_q  <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= 2'b00;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          req_q <= '{load: ex_load_i, store: ex_store_i, size: ex_size_i, uns: ex_unsigned_i,
                     addr: ex_addr_i, wdata: ex_wdata_i, rd: ex_rd_i};
          kill_q     <= 1'b0;
          wb_data_q  <= passthru ? DATA_WIDTH'(ex_addr_i) : '0;
          exc_q      <= !passthru && misal;
          exc_code_q <= ex_load_i ? 2'b01 : 2'b10;
        end
        REQ, WAIT: begin
          if (flush_i) kill_q <= 1'b1;
          if (tmo) begin
            wb_data_q  <= '0;
            exc_q      <= 1'b1;
            exc_code_q <= 2'b11;
          end else if (state_q == WAIT && dc.rvalid) begin
            wb_data_q  <= (req_q.load && !dc.err) ? load_data : '0;
            exc_q      <= dc.err;
            exc_code_q <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   tmo_cnt_q <= '0;
    else if (state_q != REQ && state_d == REQ)     tmo_cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT)    tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  assign tmo = (state_q == REQ || state_q == WAIT) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES-1));
`else
  // Without the watchdog the access never times out.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  assign dc.req   = (state_q == REQ) && !tmo;
  assign dc.we    = (state_q == REQ) && req_q.store;
  assign dc.addr  = (state_q == REQ) ? {req_q.addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;
  assign dc.be    = (state_q == REQ) ? (NB'(be_base) << off) : '0;
  assign dc.wdata = (state_q == REQ) ? (req_q.wdata << {off, 3'b000}) : '0;

  assign ex_ready_o      = (state_q == IDLE);
  assign mem_stall_o     = ex_valid_i && !ex_ready_o;
  assign wb_valid_o      = (state_q == DONE);
  assign wb_data_o       = wb_valid_o ? wb_data_q : '0;
  assign wb_rd_o         = wb_valid_o ? req_q.rd : 5'd0;
  assign mem_exception_o = wb_valid_o && exc_q;
  assign mem_exc_code_o  = mem_exception_o ? exc_code_q : 2'b00;
  assign mem_exc_addr_o  = mem_exception_o ? req_q.addr : '0;
endmodule
